// File: rtl/wb_ring_writer_if.sv
// Wishbone classic bus bundle between the ring writer (master) and dual-port RAM port B (slave).
interface wb_ring_writer_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
    logic                  we;
    logic [3:0]            sel;
    logic                  stb;
    logic                  cyc;
    logic                  ack;
    logic                  stall;

    modport master (
        output adr, dat, we, sel, stb, cyc,
        input  ack, stall
    );

    modport slave (
        input  adr, dat, we, sel, stb, cyc,
        output ack, stall
    );
endinterface

// File: rtl/wb_ring_writer.sv
// Streams samples through a small FIFO into a circular RAM region with single-word Wishbone writes.
// Optional feature macro: RING_WRITER_HALF_IRQ_EN (half-ring and wrap progress pulse on irq_o).
module wb_ring_writer #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 15,
    parameter int unsigned BASE_ADDR   = 'h4000,
    parameter int          RING_WORDS  = 256,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    // Sample handshake: a sample transfers on every cycle where sample_valid_i and
    // sample_ready_o are both high; valid while not ready drops the sample and sets overflow_o.
    input  logic                          sample_valid_i,
    input  logic [DATA_WIDTH-1:0]         sample_i,
    output logic                          sample_ready_o,
    input  logic                          clear_i,
    output logic [$clog2(RING_WORDS)-1:0] wr_idx_o,
    output logic                          overflow_o,
    output logic                          err_o,
    output logic                          irq_o,
    output logic [1:0]                    state_o,
    wb_ring_writer_if.master              wb
);

    localparam int IW = $clog2(RING_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = ($clog2(ACK_TIMEOUT + 1) < 4) ? 4 : $clog2(ACK_TIMEOUT + 1);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CW-1:0]         DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0]         TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q, rd_ptr_next;
    logic [CW-1:0]         cnt_q;

    logic [IW-1:0]         wr_idx_q, idx_next;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  stb_q, stb_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [3:0]            sel_q;
    logic                  ovf_q, err_q;

    logic                  full, push, pop, inc_idx, set_err, more_after_pop;

    function automatic logic [ADDR_WIDTH-1:0] ring_adr(input logic [IW-1:0] idx);
        return BASE + ADDR_WIDTH'({idx, 2'b00});
    endfunction

    // Readiness depends only on the registered count, so a full FIFO drops even when popping.
    assign full           = (cnt_q == DEPTH_C);
    assign sample_ready_o = ~full;
    assign push           = sample_valid_i & ~full & ~clear_i;
    assign rd_ptr_next    = rd_ptr_q + PW'(1);
    assign idx_next       = wr_idx_q + IW'(1);
    // A same-cycle push counts as the follow-on word; its data is forwarded from sample_i.
    assign more_after_pop = (cnt_q > CW'(1)) | push;

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        inc_idx = 1'b0;
        set_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (cnt_q != '0) begin
                    state_d = ST_WRITE;
                    stb_d   = 1'b1;
                    adr_d   = ring_adr(wr_idx_q);
                    dat_d   = fifo_mem[rd_ptr_q];
                end
            end
            ST_WRITE: begin
                if (wb.ack) begin
                    pop     = 1'b1;
                    inc_idx = 1'b1;
                    tmo_d   = '0;
                    if (more_after_pop) begin
                        adr_d = ring_adr(idx_next);
                        dat_d = (cnt_q > CW'(1)) ? fifo_mem[rd_ptr_next] : sample_i;
                    end else begin
                        stb_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else if (wb.stall || (tmo_q == TMO_LAST)) begin
                    // Abort: the head word is discarded and the ring index stays put.
                    pop     = 1'b1;
                    set_err = 1'b1;
                    stb_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_ERR: begin
                stb_d = 1'b0;
            end
            default: begin
                stb_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            stb_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= 4'h0;
            tmo_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            wr_idx_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            state_q  <= ST_IDLE;
            stb_q    <= 1'b0;
            sel_q    <= 4'hF;
            tmo_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            wr_idx_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= 4'hF;
            tmo_q   <= tmo_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_next;
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (inc_idx) begin
                wr_idx_q <= idx_next;
            end
            if (sample_valid_i && full) begin
                ovf_q <= 1'b1;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sample_i;
        end
    end

`ifdef RING_WRITER_HALF_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= inc_idx && ((idx_next == IW'(RING_WORDS / 2)) || (idx_next == '0));
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    // cyc and stb always move together: one single-word cycle at a time.
    assign wb.cyc     = stb_q;
    assign wb.stb     = stb_q;
    assign wb.we      = stb_q;
    assign wb.sel     = sel_q;
    assign wb.adr     = adr_q;
    assign wb.dat     = dat_q;
    assign wr_idx_o   = wr_idx_q;
    assign overflow_o = ovf_q;
    assign err_o      = err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_wb_ring_writer.sv
// Bench for wb_ring_writer: RAM responder, ring-order scoreboard, directed tables and a random stream.
module tb_wb_ring_writer;
    localparam int              AW   = 15;
    localparam int              DW   = 32;
    localparam int              RW   = 256;
    localparam int              IW   = 8;
    localparam logic [AW-1:0]   BASE = 15'h4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic [31:0]   sample;
    logic          sample_ready;
    logic          clear;
    logic [IW-1:0] wr_idx;
    logic          overflow;
    logic          err;
    logic          irq;
    logic [1:0]    state_dbg;

    wb_ring_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_ring_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR('h4000),
        .RING_WORDS(RW), .FIFO_DEPTH(4), .ACK_TIMEOUT(15)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .sample_valid_i(sample_valid), .sample_i(sample), .sample_ready_o(sample_ready),
        .clear_i(clear), .wr_idx_o(wr_idx), .overflow_o(overflow), .err_o(err),
        .irq_o(irq), .state_o(state_dbg), .wb(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [46:0] exp_q[$];
    int          m_idx = 0;
    int          exp_irq = 0;
    int          irq_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Ring model: every accepted sample lands at the next ring slot in order.
    task automatic expect_write(input logic [31:0] d);
        logic [AW-1:0] a;
        a = BASE + AW'(4 * m_idx);
        exp_q.push_back({a, d});
        m_idx = (m_idx + 1) % RW;
        if (m_idx == RW / 2 || m_idx == 0) exp_irq++;
    endtask

    task automatic sb_write(input logic [46:0] got, input logic [3:0] sel);
        logic [46:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_write actual=%0h required=none", got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e || sel !== 4'hF) begin
                errors++;
                $display("FAIL sb_write actual=%0h sel=%0h required=%0h sel=f", got, sel, e);
            end
        end
    endtask

    // RAM port B responder: registered ack on a good write, registered stall on a bad address.
    logic [31:0] ram [0:8191];
    logic        ram_ack, ram_stall;
    logic        ack_en = 1'b1;
    logic        ram_bad = 1'b0;
    logic        inj_ack = 1'b0;

    assign bus.ack   = ram_ack | inj_ack;
    assign bus.stall = ram_stall;

    always @(posedge clk) begin
        if (rst) begin
            ram_ack   <= 1'b0;
            ram_stall <= 1'b0;
        end else begin
            ram_ack   <= 1'b0;
            ram_stall <= 1'b0;
            if (bus.cyc && bus.stb && bus.we && !ram_ack && !ram_stall) begin
                if (ram_bad) begin
                    ram_stall <= 1'b1;
                end else if (ack_en) begin
                    ram[bus.adr[14:2]] <= bus.dat;
                    ram_ack <= 1'b1;
                    sb_write({bus.adr, bus.dat}, bus.sel);
                end
            end
        end
    end

    always @(negedge clk) if (irq === 1'b1) irq_cnt++;

    task automatic push1(input logic [31:0] d);
        sample_valid = 1'b1;
        sample = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_dut();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_idx = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((bus.cyc || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (bus.cyc || exp_q.size() != 0) ? 64'd0 : 64'd1, 64'd1);
    endtask

    typedef struct {
        logic [31:0]   data;
        logic [AW-1:0] adr;
        logic [IW-1:0] idx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int hi;
        int n;
        logic [31:0] d;

        vecs[0] = '{32'hDEADBEEF, 15'h4000, 8'd1};
        vecs[1] = '{32'h00000000, 15'h4004, 8'd2};
        vecs[2] = '{32'hFFFFFFFF, 15'h4008, 8'd3};
        vecs[3] = '{32'hA5A55A5A, 15'h400C, 8'd4};

        rst = 1'b1; sample_valid = 1'b0; sample = '0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cyc", bus.cyc, 0);
        check("rst_stb", bus.stb, 0);
        check("rst_we", bus.we, 0);
        check("rst_sel", bus.sel, 0);
        check("rst_adr", bus.adr, 0);
        check("rst_dat", bus.dat, 0);
        check("rst_idx", wr_idx, 0);
        check("rst_flags", {overflow, err, irq}, 0);
        check("rst_ready", sample_ready, 1);
        rst = 1'b0;

        // Single samples: latency, bus fields, RAM content and index.
        for (int i = 0; i < 4; i++) begin
            expect_write(vecs[i].data);
            push1(vecs[i].data);
            check("lat_stb_early", bus.stb, 0);
            @(negedge clk);
            check("lat_stb", bus.stb & bus.cyc, 1);
            check("adr", bus.adr, vecs[i].adr);
            check("sel", bus.sel, 4'hF);
            check("we", bus.we, 1);
            check("dat", bus.dat, vecs[i].data);
            idle(2);
            check("idx", wr_idx, vecs[i].idx);
            check("stb_drop", bus.stb, 0);
            check("ram", ram[vecs[i].adr[14:2]], vecs[i].data);
            check("irq_quiet", irq, 0);
        end

        // Back-to-back burst of four.
        clear_dut();
        check("clr_idx", wr_idx, 0);
        for (int k = 1; k <= 4; k++) expect_write(32'(k));
        hi = 0;
        for (int k = 1; k <= 4; k++) begin
            sample_valid = 1'b1;
            sample = 32'(k);
            @(negedge clk);
            if (bus.stb) hi++;
        end
        sample_valid = 1'b0;
        n = 0;
        while (bus.stb && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.stb) hi++;
        end
        check("burst_stb_cycles", hi, 8);
        wait_idle("burst_drain", 40);
        check("burst_idx", wr_idx, 4);
        check("burst_ovf", overflow, 0);

        // Overflow while the ack is withheld.
        clear_dut();
        check("clr_ovf_pre", overflow, 0);
        ack_en = 1'b0;
        for (int k = 1; k <= 4; k++) expect_write(32'h100 + 32'(k));
        for (int k = 1; k <= 6; k++) begin
            sample_valid = 1'b1;
            sample = 32'h100 + 32'(k);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_ready", sample_ready, 0);
        idle(2);
        ack_en = 1'b1;
        wait_idle("ovf_drain", 60);
        check("ovf_idx", wr_idx, 4);
        check("ovf_sticky", overflow, 1);
        check("ovf_err", err, 0);
        clear_dut();
        check("clr_ovf", overflow, 0);

        // Bad address: stall aborts, clear recovers from index 0.
        ram_bad = 1'b1;
        push1(32'hBAD00001);
        idle(3);
        check("stall_err", err, 1);
        check("stall_cyc", bus.cyc, 0);
        check("stall_idx", wr_idx, 0);
        ram_bad = 1'b0;
        check("err_ready", sample_ready, 1);
        push1(32'h00001234);
        idle(3);
        check("err_hold_cyc", bus.cyc, 0);
        clear_dut();
        check("clr_err", err, 0);
        idle(2);
        check("clr_flushed", bus.cyc, 0);
        expect_write(32'h0000600D);
        push1(32'h0000600D);
        wait_idle("retry_drain", 20);
        check("retry_idx", wr_idx, 1);
        check("retry_ram", ram[13'h1000], 32'h0000600D);

        // Ack timeout, then a late ack that must be ignored.
        clear_dut();
        ack_en = 1'b0;
        push1(32'h77770000);
        hi = 0;
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.stb) hi++;
        end
        check("tmo_cycles", hi, 15);
        check("tmo_err", err, 1);
        check("tmo_cyc", bus.cyc, 0);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        idle(2);
        check("late_ack_idx", wr_idx, 0);
        check("late_ack_cyc", bus.cyc, 0);
        ack_en = 1'b1;
        clear_dut();

        // Clear during a write, then a stray ack.
        ack_en = 1'b0;
        push1(32'hABCD0001);
        idle(2);
        clear_dut();
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        idle(2);
        check("abort_idx", wr_idx, 0);
        check("abort_cyc", bus.cyc, 0);
        ack_en = 1'b1;

        // Sample coincident with clear is discarded.
        clear = 1'b1;
        sample_valid = 1'b1;
        sample = 32'h0000C1EA;
        @(negedge clk);
        clear = 1'b0;
        sample_valid = 1'b0;
        m_idx = 0;
        idle(4);
        check("clr_drop_cyc", bus.cyc, 0);
        check("clr_drop_idx", wr_idx, 0);

        // Random stream across the ring wrap.
        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            expect_write(d);
            push1(d);
            idle($urandom_range(1, 3));
        end
        wait_idle("rand_drain", 100);
        check("rand_idx", wr_idx, IW'(m_idx));
        check("rand_ovf", overflow, 0);
        check("rand_err", err, 0);
        idle(2);
`ifdef RING_WRITER_HALF_IRQ_EN
        check("irq_pulses", irq_cnt, exp_irq);
`else
        check("irq_pulses", irq_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
